// File: rtl/xoodyak_digest_collector.sv
// Xoodyak hash byte-stream to digest collector with valid/ready output.
// Optional digest compare enabled by defining DIGEST_CMP_EN.
module xoodyak_digest_collector #(
  parameter int HASH_BYTES = 32,
  parameter int CW         = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              hash_in,
  input  logic                    hash_valid,
  output logic [8*HASH_BYTES-1:0] digest,
  output logic                    digest_valid,
  input  logic                    digest_ready,
  output logic [CW-1:0]           byte_count,
  output logic                    err,
  output logic                    match,
  input  logic [8*HASH_BYTES-1:0] expected
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(HASH_BYTES - 1);

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    take;
  logic                    last;
  logic [8*HASH_BYTES-1:0] dig_nx;

  // start restarts the count, so a coincident byte lands in slot 0
  always_comb begin
    cnt    = start ? '0 : byte_count;
    take   = hash_valid && (start || state == COLLECT);
    last   = (cnt == LAST);
    dig_nx = digest;
    dig_nx[8*cnt +: 8] = hash_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      digest       <= '0;
      digest_valid <= 1'b0;
      byte_count   <= '0;
      err          <= 1'b0;
    end else begin
      if (start) begin
        state        <= COLLECT;
        digest_valid <= 1'b0;
        byte_count   <= '0;
        err          <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (hash_valid) err <= 1'b1;
          end
          COLLECT: ;
          HOLD: begin
            if (hash_valid) err <= 1'b1;
            if (digest_ready) begin
              state        <= IDLE;
              digest_valid <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (take) begin
        digest     <= dig_nx;
        byte_count <= cnt + 1'b1;
        if (last) begin
          state        <= HOLD;
          digest_valid <= 1'b1;
        end
      end
    end
  end

`ifdef DIGEST_CMP_EN
  logic match_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q <= 1'b0;
    end else if (take && last) begin
      match_q <= (dig_nx == expected);
    end else if (start) begin
      match_q <= 1'b0;
    end
  end

  assign match = match_q;
`else
  logic unused_expected;

  assign unused_expected = ^expected;
  assign match           = 1'b0;
`endif

endmodule

// File: tb/tb_xoodyak_digest_collector.sv
// Self-checking bench for xoodyak_digest_collector.
// Drives a 32-byte and a 4-byte instance.
module tb_xoodyak_digest_collector;

`ifdef DIGEST_CMP_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   hash_in = '0;
  logic         hash_valid = 1'b0;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready = 1'b0;
  logic [5:0]   byte_count;
  logic         err;
  logic         match;
  logic [255:0] expected = '0;

  logic         start_b = 1'b0;
  logic [7:0]   hin_b = '0;
  logic         hv_b = 1'b0;
  logic [31:0]  digest_b;
  logic         dv_b;
  logic         rdy_b = 1'b0;
  logic [2:0]   cnt_b;
  logic         err_b;
  logic         match_b;
  logic [31:0]  exp_b = '0;

  int checks = 0;
  int errors = 0;

  xoodyak_digest_collector #(
    .HASH_BYTES(32),
    .CW(6)
  ) dut_a (
    .clk(clk),
    .reset(reset),
    .start(start),
    .hash_in(hash_in),
    .hash_valid(hash_valid),
    .digest(digest),
    .digest_valid(digest_valid),
    .digest_ready(digest_ready),
    .byte_count(byte_count),
    .err(err),
    .match(match),
    .expected(expected)
  );

  xoodyak_digest_collector #(
    .HASH_BYTES(4),
    .CW(3)
  ) dut_b (
    .clk(clk),
    .reset(reset),
    .start(start_b),
    .hash_in(hin_b),
    .hash_valid(hv_b),
    .digest(digest_b),
    .digest_valid(dv_b),
    .digest_ready(rdy_b),
    .byte_count(cnt_b),
    .err(err_b),
    .match(match_b),
    .expected(exp_b)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string        tag,
    input logic [255:0] obs,
    input logic [255:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference digest: byte i of the stream occupies bits [8i+7:8i]
  function automatic logic [255:0] pack(
    input logic [7:0] b[32],
    input int         n
  );
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  logic [7:0]   seq[32];
  logic [7:0]   rb[32];
  logic [255:0] ref_d;
  logic [255:0] old_d;

  initial begin
    for (int i = 0; i < 32; i++) seq[i] = 8'(i);

    cyc();
    cyc();
    check("rst_digest", digest, 256'd0);
    check("rst_valid", digest_valid, 0);
    check("rst_count", byte_count, 0);
    check("rst_err", err, 0);
    check("rst_match", match, 0);
    reset = 1'b0;
    cyc();

    // incrementing stream 0x00..0x1F
    ref_d    = pack(seq, 32);
    expected = ref_d;
    start    = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      hash_valid = 1'b1;
      hash_in    = seq[i];
      cyc();
      if (i == 30) check("valid_early", digest_valid, 0);
    end
    hash_valid = 1'b0;
    check("s1_valid", digest_valid, 1);
    check("s1_digest", digest, ref_d);
    check("s1_count", byte_count, 32);
    check("s1_err", err, 0);
    check("s1_match", match, 256'(CMP));

    // hold, then stray byte while pending
    repeat (5) cyc();
    check("hold_valid", digest_valid, 1);
    hash_valid = 1'b1;
    hash_in    = 8'h55;
    cyc();
    hash_valid = 1'b0;
    check("hold_digest", digest, ref_d);
    check("hold_err", err, 1);
    check("hold_valid2", digest_valid, 1);
    check("hold_sat", byte_count, 32);
    digest_ready = 1'b1;
    cyc();
    digest_ready = 1'b0;
    check("hs_valid", digest_valid, 0);
    hash_valid = 1'b1;
    hash_in    = 8'h77;
    cyc();
    hash_valid = 1'b0;
    check("idle_ignore", digest, ref_d);
    check("idle_count", byte_count, 32);

    // start clears flags but not digest
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("clr_err", err, 0);
    check("clr_count", byte_count, 0);
    check("clr_match", match, 0);
    check("keep_digest", digest, ref_d);

    // start with a coincident byte
    start      = 1'b1;
    hash_valid = 1'b1;
    hash_in    = 8'hAA;
    cyc();
    start = 1'b0;
    check("sv_count", byte_count, 1);
    check("sv_byte0", digest[7:0], 8'hAA);
    for (int i = 1; i < 10; i++) begin
      hash_in = 8'($urandom);
      cyc();
    end
    hash_valid = 1'b0;
    check("ten_count", byte_count, 10);
    #2 reset = 1'b1;
    #1;
    check("ar_digest", digest, 256'd0);
    check("ar_count", byte_count, 0);
    check("ar_valid", digest_valid, 0);
    check("ar_err", err, 0);
    check("ar_match", match, 0);
    cyc();
    reset = 1'b0;
    cyc();

    // stray byte in IDLE
    hash_valid = 1'b1;
    hash_in    = 8'h3C;
    cyc();
    hash_valid = 1'b0;
    check("idle_err", err, 1);
    check("idle_digest", digest, 256'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("idle_clr", err, 0);

    // random bytes with random gaps
    for (int i = 0; i < 32; i++) rb[i] = 8'($urandom);
    ref_d    = pack(rb, 32);
    expected = ref_d;
    for (int i = 0; i < 32; i++) begin
      hash_valid = 1'b1;
      hash_in    = rb[i];
      cyc();
      hash_valid = 1'b0;
      check("rnd_count", byte_count, 256'(i + 1));
      repeat ($urandom_range(0, 2)) cyc();
    end
    check("rnd_digest", digest, ref_d);
    check("rnd_valid", digest_valid, 1);
    check("rnd_err", err, 0);
    check("rnd_match", match, 256'(CMP));

    // same stream with byte 7 corrupted
    old_d = ref_d;
    rb[7] = rb[7] ^ 8'h5A;
    start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      hash_valid = 1'b1;
      hash_in    = rb[i];
      cyc();
      start = 1'b0;
    end
    hash_valid = 1'b0;
    check("bad_digest", digest, pack(rb, 32));
    check("bad_differs", 256'(digest != old_d), 1);
    check("bad_match", match, 0);
    digest_ready = 1'b1;
    cyc();
    digest_ready = 1'b0;
    check("bad_hs", digest_valid, 0);

    // 4-byte instance, gapped input
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    seq[0] = 8'hDE;
    seq[1] = 8'hAD;
    seq[2] = 8'hBE;
    seq[3] = 8'hEF;
    for (int i = 0; i < 4; i++) begin
      hv_b  = 1'b1;
      hin_b = seq[i];
      cyc();
      hv_b = 1'b0;
      if (i < 3) check("b_pend", dv_b, 0);
      cyc();
      cyc();
    end
    check("b_digest", digest_b, 32'hEFBEADDE);
    check("b_valid", dv_b, 1);
    check("b_count", cnt_b, 4);
    check("b_match", match_b, 0);
    start_b = 1'b1;
    rdy_b   = 1'b1;
    cyc();
    start_b = 1'b0;
    rdy_b   = 1'b0;
    check("b2b_valid", dv_b, 0);
    check("b2b_count", cnt_b, 0);
    hv_b  = 1'b1;
    hin_b = 8'h11;
    cyc();
    hv_b = 1'b0;
    check("b2b_collect", cnt_b, 1);
    check("b2b_err", err_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
